// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between a PLL lock supervisor and the PLL / downstream reset tree.
// The PLL side drives pll_lock. The supervisor drives the reset and status outputs.
interface pll_lock_supervisor_if;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       locked;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] unlock_cnt;

  modport master (output pll_lock,
                  input  pll_reset, sys_rst_n, locked, fail, retry_cnt, unlock_cnt);
  modport slave  (input  pll_lock,
                  output pll_reset, sys_rst_n, locked, fail, retry_cnt, unlock_cnt);
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset pulse, waits for lock, and filters lock for stability.
// Releases the downstream reset only after lock is stable, retries on timeout, and latches FAIL.
module pll_lock_supervisor #(
  parameter int RESET_PULSE   = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 2700,
  parameter int RETRY_MAX     = 7
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  pll_lock_supervisor_if.slave io
);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int MW = (LW > SW) ? LW : SW;
  localparam int CW = (MW > 16) ? MW : 16;

  localparam logic [CW-1:0] CNT_RP = CW'(RESET_PULSE);
  localparam logic [CW-1:0] CNT_LT = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_ST = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_1  = CW'(1);
  localparam logic [3:0]    RMAX   = 4'(RETRY_MAX);

  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    unlock_q, unlock_d;
  logic          pll_reset_q, pll_reset_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;
  logic          lock_s;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    unlock_d = unlock_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == CNT_1) begin
          state_d = WAIT_LOCK;
          cnt_d   = CNT_LT;
        end else begin
          cnt_d = cnt_q - CNT_1;
        end
      end
      // A lock seen on the timeout cycle takes priority over the retry.
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = CNT_ST;
        end else if (cnt_q == CNT_1) begin
          if (retry_q < RMAX) begin
            retry_d = retry_q + 4'd1;
            state_d = PLL_RST;
            cnt_d   = CNT_RP;
          end else begin
            state_d = FAIL;
          end
        end else begin
          cnt_d = cnt_q - CNT_1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = CNT_LT;
        end else if (cnt_q == CNT_1) begin
          state_d = RUN;
          retry_d = 4'd0;
        end else begin
          cnt_d = cnt_q - CNT_1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          if (unlock_q != 8'hFF) unlock_d = unlock_q + 8'd1;
          state_d = PLL_RST;
          cnt_d   = CNT_RP;
        end
      end
      FAIL: state_d = FAIL;
      default: begin
        state_d = PLL_RST;
        cnt_d   = CNT_RP;
      end
    endcase
    // Outputs are decoded from the next state so they switch on the same edge as the state.
    pll_reset_d = (state_d == PLL_RST);
    sys_rst_n_d = (state_d == RUN);
    locked_d    = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= CNT_RP;
      sync_q      <= 2'b00;
      retry_q     <= 4'd0;
      unlock_q    <= 8'd0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[0], io.pll_lock};
      retry_q     <= retry_d;
      unlock_q    <= unlock_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign io.pll_reset  = pll_reset_q;
  assign io.sys_rst_n  = sys_rst_n_q;
  assign io.locked     = locked_q;
  assign io.fail       = fail_q;
  assign io.retry_cnt  = retry_q;
  assign io.unlock_cnt = unlock_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
// Edge counts in the comments are the clkin rising edges after the last event.
module tb_pll_lock_supervisor;
  logic clkin;
  logic rst_n;
  int   tests;
  int   fails;

  pll_lock_supervisor_if io ();

  pll_lock_supervisor #(
    .RESET_PULSE(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .RETRY_MAX(2)
  ) dut (
    .clkin(clkin),
    .rst_n(rst_n),
    .io   (io.slave)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, 32'(io.pll_reset), 32'd1);
    chk({tag, "_sys_rst_n"}, 32'(io.sys_rst_n), 32'd0);
    chk({tag, "_locked"},    32'(io.locked),    32'd0);
    chk({tag, "_fail"},      32'(io.fail),      32'd0);
    chk({tag, "_retry"},     32'(io.retry_cnt), 32'd0);
    chk({tag, "_unlock"},    32'(io.unlock_cnt), 32'd0);
  endtask

  task automatic wait_locked(input string tag);
    int n = 0;
    while (io.locked !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(io.locked), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    io.pll_lock = 1'b0;
    #23;
    chk_reset_vals("por");

    // Nominal bring-up
    @(posedge clkin); #1;
    rst_n = 1'b1;
    tick(3);  chk("nom_prst_e3", 32'(io.pll_reset), 32'd1);
    tick(1);  chk("nom_prst_e4", 32'(io.pll_reset), 32'd0);
    tick(1);  io.pll_lock = 1'b1;
    tick(10); chk("nom_locked_e15", 32'(io.locked), 32'd0);
              chk("nom_srst_e15",   32'(io.sys_rst_n), 32'd0);
    tick(1);  chk("nom_locked_e16", 32'(io.locked), 32'd1);
              chk("nom_srst_e16",   32'(io.sys_rst_n), 32'd1);
              chk("nom_retry",      32'(io.retry_cnt), 32'd0);

    // Loss of lock in RUN
    io.pll_lock = 1'b0;
    tick(2);  chk("lol_locked_a2", 32'(io.locked), 32'd1);
    tick(1);  chk("lol_srst_a3",   32'(io.sys_rst_n), 32'd0);
              chk("lol_locked_a3", 32'(io.locked), 32'd0);
              chk("lol_unlock_a3", 32'(io.unlock_cnt), 32'd1);
              chk("lol_prst_a3",   32'(io.pll_reset), 32'd1);
    tick(3);  chk("lol_prst_a6",   32'(io.pll_reset), 32'd1);
    tick(1);  chk("lol_prst_a7",   32'(io.pll_reset), 32'd0);
    io.pll_lock = 1'b1;
    tick(10); chk("lol_locked_b10", 32'(io.locked), 32'd0);
    tick(1);  chk("lol_locked_b11", 32'(io.locked), 32'd1);
              chk("lol_retry_b11",  32'(io.retry_cnt), 32'd0);

    // Chatter during STABLE: one low sample restarts the stability window
    io.pll_lock = 1'b0;
    tick(3);  chk("cht_unlock_c3", 32'(io.unlock_cnt), 32'd2);
    tick(4);  chk("cht_prst_c7",   32'(io.pll_reset), 32'd0);
    io.pll_lock = 1'b1;
    tick(5);  io.pll_lock = 1'b0;
    tick(1);  io.pll_lock = 1'b1;
    tick(10); chk("cht_locked_d16", 32'(io.locked), 32'd0);
              chk("cht_retry_d16",  32'(io.retry_cnt), 32'd0);
    tick(1);  chk("cht_locked_d17", 32'(io.locked), 32'd1);

    // Never locks: two retries, then FAIL
    io.pll_lock = 1'b0;
    tick(3);  chk("nl_unlock_e3",  32'(io.unlock_cnt), 32'd3);
    tick(4);
    tick(19); chk("nl_prst_e26",   32'(io.pll_reset), 32'd0);
              chk("nl_retry_e26",  32'(io.retry_cnt), 32'd0);
    tick(1);  chk("nl_prst_e27",   32'(io.pll_reset), 32'd1);
              chk("nl_retry_e27",  32'(io.retry_cnt), 32'd1);
    tick(24); chk("nl_prst_e51",   32'(io.pll_reset), 32'd1);
              chk("nl_retry_e51",  32'(io.retry_cnt), 32'd2);
    tick(23); chk("nl_fail_e74",   32'(io.fail), 32'd0);
    tick(1);  chk("nl_fail_e75",   32'(io.fail), 32'd1);
              chk("nl_prst_e75",   32'(io.pll_reset), 32'd0);
              chk("nl_retry_e75",  32'(io.retry_cnt), 32'd2);
              chk("nl_srst_e75",   32'(io.sys_rst_n), 32'd0);
              chk("nl_locked_e75", 32'(io.locked), 32'd0);
    io.pll_lock = 1'b1;
    tick(50); chk("nl_fail_hold",  32'(io.fail), 32'd1);
              chk("nl_prst_hold",  32'(io.pll_reset), 32'd0);

    // Async reset from FAIL, then lock arriving exactly on the timeout cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_fail");
    io.pll_lock = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(23); chk("edge_prst_f23",  32'(io.pll_reset), 32'd0);
              chk("edge_retry_f23", 32'(io.retry_cnt), 32'd0);
    tick(1);  chk("edge_prst_f24",  32'(io.pll_reset), 32'd1);
              chk("edge_retry_f24", 32'(io.retry_cnt), 32'd1);
    tick(21); io.pll_lock = 1'b1;
    tick(3);  chk("edge_prst_f48",  32'(io.pll_reset), 32'd0);
              chk("edge_retry_f48", 32'(io.retry_cnt), 32'd1);
              chk("edge_fail_f48",  32'(io.fail), 32'd0);
    tick(7);  chk("edge_locked_f55", 32'(io.locked), 32'd0);
              chk("edge_retry_f55",  32'(io.retry_cnt), 32'd1);
    tick(1);  chk("edge_locked_f56", 32'(io.locked), 32'd1);
              chk("edge_retry_f56",  32'(io.retry_cnt), 32'd0);
              chk("edge_unlock_f56", 32'(io.unlock_cnt), 32'd0);

    // Loss-of-lock counter saturation
    for (int i = 0; i < 255; i++) begin
      io.pll_lock = 1'b0;
      tick(3);
      io.pll_lock = 1'b1;
      wait_locked("sat_relock");
    end
    chk("sat_unlock_255", 32'(io.unlock_cnt), 32'd255);
    io.pll_lock = 1'b0;
    tick(3);
    io.pll_lock = 1'b1;
    wait_locked("sat_relock_last");
    chk("sat_unlock_hold", 32'(io.unlock_cnt), 32'd255);
    chk("sat_retry", 32'(io.retry_cnt), 32'd0);

    // Async reset mid-RUN takes effect without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_run");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
